// File: rtl/brc_pred_unit.sv
// Branch prediction unit: 2-bit PHT plus direct-mapped BTB for fetch lookup,
// EX-stage branch/jump resolution with a registered mispredict redirect, and
// branch / mispredict performance counters.
module brc_pred_unit #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned PHT_DEPTH = 64,
  parameter int unsigned BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lk_valid_i,
  input  logic [XLEN-1:0] lk_pc_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_pc_o,
  input  logic            ex_valid_i,
  input  logic            flush_i,
  input  logic            is_jal_i,
  input  logic            is_jalr_i,
  input  logic            is_brc_i,
  input  logic [2:0]      fun_3,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            pred_taken_i,
  input  logic [XLEN-1:0] pred_pc_i,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [31:0]     brc_cnt_o,
  output logic [31:0]     mispred_cnt_o
);

  localparam int unsigned PW = $clog2(PHT_DEPTH);
  localparam int unsigned BW = $clog2(BTB_DEPTH);
  localparam int unsigned TW = XLEN - BW - 2;

  typedef struct packed {
    logic            valid;
    logic [TW-1:0]   tag;
    logic            uncond;
    logic [XLEN-1:0] target;
  } btb_entry_t;

  logic [1:0] pht [PHT_DEPTH];
  btb_entry_t btb [BTB_DEPTH];

  logic [31:0] brc_cnt;
  logic [31:0] mispred_cnt;

  // ---------------- lookup ----------------
  logic [PW-1:0] lk_pidx;
  logic [BW-1:0] lk_bidx;
  logic [TW-1:0] lk_tag;
  btb_entry_t    lk_entry;
  logic          lk_hit;

  assign lk_pidx = lk_pc_i[PW+1:2];
  assign lk_bidx = lk_pc_i[BW+1:2];
  assign lk_tag  = lk_pc_i[XLEN-1:BW+2];

  // Combinational prediction from current (pre-update) table contents
  always_comb begin
    lk_entry     = btb[lk_bidx];
    lk_hit       = lk_entry.valid && (lk_entry.tag == lk_tag);
    pred_taken_o = lk_valid_i && lk_hit && (lk_entry.uncond || pht[lk_pidx][1]);
    pred_pc_o    = pred_taken_o ? lk_entry.target : lk_pc_i + XLEN'(4);
  end

  // ---------------- resolve ----------------
  logic            rv;
  logic [XLEN:0]   sub;
  logic            zero, sign, ovf, carry, cond;
  logic [XLEN-1:0] jalr_sum, target, nxt;
  logic            act, mp;
  logic [PW-1:0]   ex_pidx;
  logic [BW-1:0]   ex_bidx;
  logic [TW-1:0]   ex_tag;

  assign rv      = ex_valid_i & ~flush_i;
  assign sub     = {1'b0, rs1_i} + {1'b0, ~rs2_i} + (XLEN+1)'(1);
  assign zero    = (sub[XLEN-1:0] == '0);
  assign sign    = sub[XLEN-1];
  assign carry   = sub[XLEN];
  assign ovf     = (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]) & (sign ^ rs1_i[XLEN-1]);
  assign ex_pidx = pc_i[PW+1:2];
  assign ex_bidx = pc_i[BW+1:2];
  assign ex_tag  = pc_i[XLEN-1:BW+2];

  // Branch condition decode
  always_comb begin
    cond = 1'b0;
    case (fun_3)
      3'b000:  cond = zero;
      3'b001:  cond = ~zero;
      3'b100:  cond = sign ^ ovf;
      3'b101:  cond = ~(sign ^ ovf);
      3'b110:  cond = ~carry;
      3'b111:  cond = carry;
      default: cond = 1'b0;
    endcase
  end

  // Target, actual outcome, next PC and mispredict detection
  always_comb begin
    jalr_sum = rs1_i + imm_i;
    target   = is_jalr_i ? {jalr_sum[XLEN-1:1], 1'b0} : pc_i + imm_i;
    act      = is_jal_i | is_jalr_i | (is_brc_i & cond);
    nxt      = act ? target : pc_i + XLEN'(4);
    mp       = rv & ((act != pred_taken_i) | (act & (target != pred_pc_i)));
  end

  // PHT: saturating 2-bit counters, trained by resolved conditional branches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < PHT_DEPTH; i++) pht[i] <= 2'b01;
    end else if (rv && is_brc_i) begin
      if (act && pht[ex_pidx] != 2'b11)
        pht[ex_pidx] <= pht[ex_pidx] + 2'd1;
      else if (!act && pht[ex_pidx] != 2'b00)
        pht[ex_pidx] <= pht[ex_pidx] - 2'd1;
    end
  end

  // BTB: allocate/refresh on every taken control transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BTB_DEPTH; i++) btb[i] <= '0;
    end else if (rv && act) begin
      btb[ex_bidx] <= '{valid: 1'b1, tag: ex_tag, uncond: is_jal_i | is_jalr_i, target: target};
    end
  end

  // Registered redirect: one-cycle pulse, PC held between mispredicts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
    end else begin
      redirect_o <= mp;
      if (mp) redirect_pc_o <= nxt;
    end
  end

  // Performance counters, free-running with natural wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brc_cnt     <= '0;
      mispred_cnt <= '0;
    end else begin
      if (rv && is_brc_i) brc_cnt <= brc_cnt + 32'd1;
      if (mp) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

  assign brc_cnt_o     = brc_cnt;
  assign mispred_cnt_o = mispred_cnt;

endmodule

// File: tb/tb_brc_pred_unit.sv
// Directed testbench for brc_pred_unit: a vector table of resolves with
// hand-computed redirect results, then sequences for PHT saturation, lookup,
// flush, asynchronous reset and counter wrap.
module tb_brc_pred_unit;

  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        lk_valid_i;
  logic [63:0] lk_pc_i;
  logic        pred_taken_o;
  logic [63:0] pred_pc_o;
  logic        ex_valid_i, flush_i, is_jal_i, is_jalr_i, is_brc_i;
  logic [2:0]  fun_3;
  logic [63:0] rs1_i, rs2_i, imm_i, pc_i;
  logic        pred_taken_i;
  logic [63:0] pred_pc_i;
  logic        redirect_o;
  logic [63:0] redirect_pc_o;
  logic [31:0] brc_cnt_o, mispred_cnt_o;

  brc_pred_unit #(.XLEN(64), .PHT_DEPTH(64), .BTB_DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .lk_valid_i(lk_valid_i), .lk_pc_i(lk_pc_i),
    .pred_taken_o(pred_taken_o), .pred_pc_o(pred_pc_o),
    .ex_valid_i(ex_valid_i), .flush_i(flush_i),
    .is_jal_i(is_jal_i), .is_jalr_i(is_jalr_i), .is_brc_i(is_brc_i),
    .fun_3(fun_3), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i), .pc_i(pc_i),
    .pred_taken_i(pred_taken_i), .pred_pc_i(pred_pc_i),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .brc_cnt_o(brc_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        jal, jalr, brc;
    logic [2:0]  f3;
    logic [63:0] rs1, rs2, imm, pc;
    logic        pt;
    logic [63:0] ppc;
    logic        red;
    logic [63:0] rpc;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic jal, jalr, brc, input logic [2:0] f3,
                              input logic [63:0] rs1, rs2, imm, pc,
                              input logic pt, input logic [63:0] ppc,
                              input logic red, input logic [63:0] rpc);
    vec_t v;
    v.jal = jal; v.jalr = jalr; v.brc = brc; v.f3 = f3;
    v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.pc = pc;
    v.pt = pt; v.ppc = ppc; v.red = red; v.rpc = rpc;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Present one resolve for a single cycle; returns at the following negedge
  task automatic resolve(input logic jal, jalr, brc, input logic [2:0] f3,
                         input logic [63:0] rs1, rs2, imm, pc,
                         input logic pt, input logic [63:0] ppc, input logic fl);
    @(negedge clk);
    is_jal_i = jal; is_jalr_i = jalr; is_brc_i = brc; fun_3 = f3;
    rs1_i = rs1; rs2_i = rs2; imm_i = imm; pc_i = pc;
    pred_taken_i = pt; pred_pc_i = ppc;
    ex_valid_i = 1'b1; flush_i = fl;
    @(negedge clk);
    ex_valid_i = 1'b0; flush_i = 1'b0;
    is_jal_i = 1'b0; is_jalr_i = 1'b0; is_brc_i = 1'b0;
  endtask

  function automatic logic [1:0] pht_of(input logic [63:0] pc);
    logic [5:0] i;
    i = pc[7:2];
    return dut.pht[i];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] exp_rpc;
    int exp_brc, exp_mp;

    vecs[0]  = mk(0,0,1,3'b000, 5, 5, 64'h40, 64'h100, 0, 0, 1, 64'h140);
    vecs[1]  = mk(0,0,1,3'b000, 5, 6, 64'h40, 64'h108, 0, 0, 0, 0);
    vecs[2]  = mk(0,0,1,3'b001, 5, 6, 64'h40, 64'h110, 0, 0, 1, 64'h150);
    vecs[3]  = mk(0,0,1,3'b001, 7, 7, 64'h40, 64'h118, 0, 0, 0, 0);
    vecs[4]  = mk(0,0,1,3'b100, MIN, 1, 64'h40, 64'h120, 0, 0, 1, 64'h160);
    vecs[5]  = mk(0,0,1,3'b110, MIN, 1, 64'h40, 64'h128, 0, 0, 0, 0);
    vecs[6]  = mk(0,0,1,3'b101, 1, MIN, 64'h40, 64'h130, 0, 0, 1, 64'h170);
    vecs[7]  = mk(0,0,1,3'b111, 1, MIN, 64'h40, 64'h138, 0, 0, 0, 0);
    vecs[8]  = mk(0,0,1,3'b110, 1, 2, 64'h40, 64'h140, 0, 0, 1, 64'h180);
    vecs[9]  = mk(0,0,1,3'b010, 5, 5, 64'h40, 64'h150, 0, 0, 0, 0);
    vecs[10] = mk(0,0,1,3'b111, MIN, 1, 64'h40, 64'h170, 0, 0, 1, 64'h1B0);
    vecs[11] = mk(0,0,1,3'b100, 1, MIN, 64'h40, 64'h178, 0, 0, 0, 0);
    vecs[12] = mk(1,0,0,3'b000, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h300, 1, 64'h2F8, 0, 0);
    vecs[13] = mk(1,0,0,3'b000, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h300, 0, 0, 1, 64'h2F8);
    vecs[14] = mk(0,0,0,3'b000, 0, 0, 0, 64'h400, 1, 64'h999, 1, 64'h404);
    vecs[15] = mk(0,0,1,3'b000, 5, 5, 64'h40, 64'h100, 1, 64'h144, 1, 64'h140);
    vecs[16] = mk(0,0,1,3'b000, 5, 6, 64'h40, 64'h160, 1, 64'h1A0, 1, 64'h164);
    vecs[17] = mk(0,1,0,3'b000, 64'h3000, 0, 64'h7, 64'h600, 0, 0, 1, 64'h3006);
    vecs[18] = mk(0,1,0,3'b000, 64'h2001, 0, 0, 64'h500, 1, 64'h2000, 0, 0);

    rst = 1'b1;
    lk_valid_i = 1'b0; lk_pc_i = '0;
    ex_valid_i = 1'b0; flush_i = 1'b0;
    is_jal_i = 1'b0; is_jalr_i = 1'b0; is_brc_i = 1'b0; fun_3 = '0;
    rs1_i = '0; rs2_i = '0; imm_i = '0; pc_i = '0;
    pred_taken_i = 1'b0; pred_pc_i = '0;

    // Reset state
    repeat (2) @(negedge clk);
    lk_valid_i = 1'b1; lk_pc_i = 64'h100;
    #1;
    check("rst_redirect", 64'(redirect_o), 0);
    check("rst_redirect_pc", redirect_pc_o, 0);
    check("rst_brc_cnt", 64'(brc_cnt_o), 0);
    check("rst_mispred_cnt", 64'(mispred_cnt_o), 0);
    check("rst_pht", 64'(pht_of(64'h100)), 1);
    check("rst_pred_taken", 64'(pred_taken_o), 0);
    check("rst_pred_pc", pred_pc_o, 64'h104);
    lk_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // beq taken, predicted not taken
    resolve(0,0,1,3'b000, 5, 5, 64'h20, 64'h1000, 0, 0, 0);
    check("beq_redirect", 64'(redirect_o), 1);
    check("beq_redirect_pc", redirect_pc_o, 64'h1020);
    check("beq_mispred_cnt", 64'(mispred_cnt_o), 1);
    check("beq_brc_cnt", 64'(brc_cnt_o), 1);
    check("beq_pht", 64'(pht_of(64'h1000)), 2);
    @(negedge clk);
    check("redirect_pulse", 64'(redirect_o), 0);
    check("redirect_pc_hold", redirect_pc_o, 64'h1020);

    // Vector table
    exp_rpc = 64'h1020; exp_brc = 1; exp_mp = 1;
    for (int i = 0; i < NV; i++) begin
      resolve(vecs[i].jal, vecs[i].jalr, vecs[i].brc, vecs[i].f3, vecs[i].rs1, vecs[i].rs2,
              vecs[i].imm, vecs[i].pc, vecs[i].pt, vecs[i].ppc, 0);
      if (vecs[i].red) begin exp_rpc = vecs[i].rpc; exp_mp++; end
      if (vecs[i].brc) exp_brc++;
      check($sformatf("vec%0d_redirect", i), 64'(redirect_o), 64'(vecs[i].red));
      check($sformatf("vec%0d_redirect_pc", i), redirect_pc_o, exp_rpc);
      check($sformatf("vec%0d_brc_cnt", i), 64'(brc_cnt_o), 64'(exp_brc));
      check($sformatf("vec%0d_mispred_cnt", i), 64'(mispred_cnt_o), 64'(exp_mp));
    end

    // BTB lookup after jalr
    lk_valid_i = 1'b1; lk_pc_i = 64'h500;
    #1;
    check("jalr_lk_taken", 64'(pred_taken_o), 1);
    check("jalr_lk_pc", pred_pc_o, 64'h2000);
    lk_valid_i = 1'b0;
    #1;
    check("lk_invalid_taken", 64'(pred_taken_o), 0);
    check("lk_invalid_pc", pred_pc_o, 64'h504);

    // Fresh state for saturation sequence
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    lk_valid_i = 1'b1; lk_pc_i = 64'h500;
    #1;
    check("rst_btb_cleared", 64'(pred_taken_o), 0);

    // First taken with simultaneous lookup: pre-update contents seen
    @(negedge clk);
    lk_valid_i = 1'b1; lk_pc_i = 64'h2044;
    is_brc_i = 1'b1; fun_3 = 3'b000; rs1_i = 5; rs2_i = 5; imm_i = 64'h10; pc_i = 64'h2044;
    pred_taken_i = 1'b0; pred_pc_i = '0; ex_valid_i = 1'b1;
    #1;
    check("rbw_pred_taken", 64'(pred_taken_o), 0);
    check("rbw_pred_pc", pred_pc_o, 64'h2048);
    @(negedge clk);
    ex_valid_i = 1'b0; is_brc_i = 1'b0;
    #1;
    check("sat1_pht", 64'(pht_of(64'h2044)), 2);
    check("sat1_pred_taken", 64'(pred_taken_o), 1);
    check("sat1_pred_pc", pred_pc_o, 64'h2054);
    for (int k = 0; k < 4; k++) resolve(0,0,1,3'b000, 5, 5, 64'h10, 64'h2044, 0, 0, 0);
    check("sat5_pht", 64'(pht_of(64'h2044)), 3);
    resolve(0,0,1,3'b000, 5, 6, 64'h10, 64'h2044, 0, 0, 0);
    check("nt1_pht", 64'(pht_of(64'h2044)), 2);
    check("nt1_redirect", 64'(redirect_o), 0);
    resolve(0,0,1,3'b000, 5, 6, 64'h10, 64'h2044, 0, 0, 0);
    check("nt2_pht", 64'(pht_of(64'h2044)), 1);
    lk_pc_i = 64'h2044;
    #1;
    check("nt2_pred_taken", 64'(pred_taken_o), 0);
    check("nt2_pred_pc", pred_pc_o, 64'h2048);
    check("sat_brc_cnt", 64'(brc_cnt_o), 7);
    check("sat_mispred_cnt", 64'(mispred_cnt_o), 5);

    // Flushed mispredicting resolve has no effect
    resolve(0,0,1,3'b000, 5, 5, 64'h20, 64'h3000, 0, 0, 1);
    lk_pc_i = 64'h3000;
    #1;
    check("flush_redirect", 64'(redirect_o), 0);
    check("flush_redirect_pc", redirect_pc_o, 64'h2054);
    check("flush_brc_cnt", 64'(brc_cnt_o), 7);
    check("flush_mispred_cnt", 64'(mispred_cnt_o), 5);
    check("flush_pht", 64'(pht_of(64'h3000)), 1);
    check("flush_btb", 64'(pred_taken_o), 0);

    // Reset asserted mid-stream, with a resolve in flight
    resolve(0,0,1,3'b000, 5, 5, 64'h20, 64'h3000, 0, 0, 0);
    #1;
    check("pre_rst_redirect", 64'(redirect_o), 1);
    check("pre_rst_pred_taken", 64'(pred_taken_o), 1);
    is_brc_i = 1'b1; fun_3 = 3'b000; rs1_i = 5; rs2_i = 5; imm_i = 64'h20; pc_i = 64'h3000;
    pred_taken_i = 1'b0; ex_valid_i = 1'b1;
    rst = 1'b1;
    #1;
    check("async_rst_redirect", 64'(redirect_o), 0);
    check("async_rst_redirect_pc", redirect_pc_o, 0);
    check("async_rst_brc_cnt", 64'(brc_cnt_o), 0);
    check("async_rst_mispred_cnt", 64'(mispred_cnt_o), 0);
    check("async_rst_pred_taken", 64'(pred_taken_o), 0);
    @(negedge clk);
    ex_valid_i = 1'b0; is_brc_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_redirect", 64'(redirect_o), 0);
    check("post_rst_mispred_cnt", 64'(mispred_cnt_o), 0);
    check("post_rst_brc_cnt", 64'(brc_cnt_o), 0);

    // Mispredict counter wrap
    force dut.mispred_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.mispred_cnt;
    #1;
    check("preload_mispred_cnt", 64'(mispred_cnt_o), 64'hFFFF_FFFF);
    resolve(1,0,0,3'b000, 0, 0, 64'h80, 64'h700, 0, 0, 0);
    check("wrap_redirect", 64'(redirect_o), 1);
    check("wrap_redirect_pc", redirect_pc_o, 64'h780);
    check("wrap_mispred_cnt", 64'(mispred_cnt_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/brc_pred_unit.md
BRC_PRED_UNIT -- requirements
Module: brc_pred_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width.
REQ-002 SHALL have parameter PHT_DEPTH, default 64, number of 2-bit counters; power of 2 and at least 2.
REQ-003 SHALL have parameter BTB_DEPTH, default 16, number of direct-mapped BTB entries; power of 2 and at least 2.
REQ-004 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port lk_valid_i, input, 1, fetch lookup request.
REQ-007 SHALL have port lk_pc_i, input, XLEN, fetch PC.
REQ-008 SHALL have port pred_taken_o, output, 1, combinational prediction.
REQ-009 SHALL have port pred_pc_o, output, XLEN, combinational predicted next PC.
REQ-010 SHALL have port ex_valid_i, input, 1, resolve request from EX.
REQ-011 SHALL have port flush_i, input, 1, kills the current resolve.
REQ-012 SHALL have ports is_jal_i, is_jalr_i and is_brc_i, input, 1 each, instruction class (one-hot or all zero).
REQ-013 SHALL have port fun_3, input, 3, branch funct3.
REQ-014 SHALL have ports rs1_i, rs2_i, imm_i and pc_i, input, XLEN each, operands, immediate and PC.
REQ-015 SHALL have ports pred_taken_i, input, 1, and pred_pc_i, input, XLEN, the prediction that travelled with the instruction.
REQ-016 SHALL have ports redirect_o, output, 1, and redirect_pc_o, output, XLEN, registered mispredict redirect.
REQ-017 SHALL have ports brc_cnt_o and mispred_cnt_o, output, 32 each, performance counters.

Function
REQ-018 Resolve SHALL be valid when rv = ex_valid_i & ~flush_i; when rv=0 there is no table, counter or redirect update.
REQ-019 Branch conditions SHALL use sub = rs1 + ~rs2 + 1 with carry-out and overflow: 000 beq zero; 001 bne ~zero; 100 blt sign^ovf; 101 bge ~(sign^ovf); 110 bltu ~carry; 111 bgeu carry; 010/011 not taken.
REQ-020 Target SHALL be (rs1_i+imm_i) with bit0 cleared for jalr, and pc_i+imm_i otherwise; all sums are modulo 2^XLEN.
REQ-021 Actual taken SHALL be act = is_jal_i | is_jalr_i | (is_brc_i & cond).
REQ-022 Next PC SHALL be nxt = act ? target : pc_i+4.
REQ-023 Mispredict SHALL be mp = rv & (act != pred_taken_i | (act & target != pred_pc_i)); this covers a non-control instruction carrying pred_taken_i=1.
REQ-024 One cycle after a resolve, redirect_o SHALL equal mp; redirect_pc_o SHALL load nxt when mp=1 and hold otherwise; redirect_o is a single-cycle pulse per mispredict.
REQ-025 PHT index SHALL be pc[log2(PHT_DEPTH)+1:2].
REQ-026 On rv & is_brc_i, the indexed PHT counter SHALL increment if act and decrement if not, saturating at 3 and 0.
REQ-027 BTB index SHALL be pc[log2(BTB_DEPTH)+1:2]; tag = pc[XLEN-1:log2(BTB_DEPTH)+2]; entry = {valid, tag, uncond, target}.
REQ-028 On rv & act, the indexed BTB entry SHALL be written with valid=1, tag, uncond=is_jal_i|is_jalr_i and target; a not-taken branch SHALL leave the BTB unchanged.
REQ-029 On lookup, hit = valid & tag match; pred_taken_o = lk_valid_i & hit & (uncond | pht[idx][1]); pred_pc_o = pred_taken_o ? entry.target : lk_pc_i+4.
REQ-030 Lookup and update in the same cycle to the same index SHALL return the pre-update contents (read-before-write).
REQ-031 brc_cnt_o SHALL increment on every rv & is_brc_i; mispred_cnt_o SHALL increment on every mp; both wrap from 0xFFFFFFFF to 0.

Reset
REQ-032 While rst=1, all PHT counters SHALL be 2'b01, all BTB valid bits 0, redirect_o=0, redirect_pc_o=0, and both counters 0, asynchronously.
REQ-033 A resolve coinciding with reset assertion SHALL be discarded; no redirect appears after reset release.

Verification
REQ-034 Bench: beq with rs1=rs2=5, pc=0x1000, imm=0x20, pred_taken_i=0 -> next cycle redirect_o=1, redirect_pc_o=0x1020, mispred_cnt_o=1, PHT[0x1000 idx]=2.
REQ-035 Bench: blt with rs1=0x8000...0, rs2=1 (overflow case) -> taken; bltu with the same operands -> not taken, with pred_taken_i=0 giving no redirect.
REQ-036 Bench: jalr with rs1=0x2001, imm=0, pred_pc_i=0x2000, pred_taken_i=1 -> no redirect; a later lookup at the same pc gives pred_taken_o=1 and pred_pc_o=0x2000.
REQ-037 Bench: same branch taken 5 times -> counter saturates at 3; then not taken twice -> counter=1 and lookup predicts not taken with pred_pc_o = pc+4.
REQ-038 Bench: flush_i=1 together with a mispredicting resolve -> redirect_o stays 0 and counters and tables are unchanged; rst pulsed mid-stream -> all outputs are 0 immediately.
REQ-039 Bench: preload mispred_cnt to 0xFFFFFFFF via 2^32 events (or force) then one more mispredict -> mispred_cnt_o=0.
